// File: rtl/cs_stream_checker.sv
// cs_stream_checker: on-chip self-checker for the CS smoothing datapath.
// Compares the Y stream, one word per clock, against golden words preloaded
// into an internal FIFO, and reports check/error counts and pass/fail.
//
// Optional build macro: CS_CHK_FIRSTERR_EN
//   defined   - first_idx/first_exp/first_act capture the first failed compare
//   undefined - those ports exist but are tied to 0
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      one-cycle pulse, begins a run (from IDLE or DONE)
//   Y          CS output word, compared every CHECK cycle
//   gold_data  golden word, pushed on gold_valid & gold_ready
//   gold_valid golden word valid
//   gold_ready FIFO not full
//   busy       in WARM or CHECK
//   done       in DONE
//   pass       in DONE with no errors and no underrun
//   mismatch   one-cycle pulse per failed compare
//   underrun   sticky, a compare found the FIFO empty
//   chk_cnt    compares performed this run
//   err_cnt    failed compares, saturating
//   first_*    first failed compare: index, expected word, actual word
module cs_stream_checker #(
  parameter int unsigned DW     = 10,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned WARMUP = 9,
  parameter int unsigned N_CHK  = 1992,
  parameter int unsigned CW     = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] Y,
  input  logic [DW-1:0] gold_data,
  input  logic          gold_valid,
  output logic          gold_ready,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          mismatch,
  output logic          underrun,
  output logic [CW-1:0] chk_cnt,
  output logic [CW-1:0] err_cnt,
  output logic [CW-1:0] first_idx,
  output logic [DW-1:0] first_exp,
  output logic [DW-1:0] first_act
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;
  localparam int unsigned WW = $clog2(WARMUP + 1);
  // Run length counter sized for N_CHK so the run ends correctly even when
  // CW is too narrow to hold N_CHK.
  localparam int unsigned RW = $clog2(N_CHK + 1);

  typedef enum logic [1:0] {S_IDLE, S_WARM, S_CHECK, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] warm_q, warm_d;
  logic [RW-1:0] run_q, run_d;
  logic [CW-1:0] chk_d, err_d;
  logic          und_d, mis_d, busy_d, done_d, pass_d, ready_d;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [OW-1:0] cnt_q, cnt_d;

  logic          run_start_c, in_check_c, fifo_empty_c, push_c, pop_c;
  logic          miss_c, warm_last_c, run_last_c;
  logic [DW-1:0] head_c;

  assign run_start_c  = start && (state_q == S_IDLE || state_q == S_DONE);
  assign in_check_c   = (state_q == S_CHECK);
  assign fifo_empty_c = (cnt_q == '0);
  assign push_c       = gold_valid && gold_ready;
  assign pop_c        = in_check_c && !fifo_empty_c;
  assign head_c       = mem[rd_ptr];
  // 4-state exact compare so X/Z on Y is reported as a failure.
  assign miss_c       = in_check_c && (fifo_empty_c || (Y !== head_c));
  assign warm_last_c  = (warm_q == WW'(WARMUP - 1));
  assign run_last_c   = (run_q == RW'(N_CHK - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)       state_d = S_WARM;
      S_WARM:  if (warm_last_c) state_d = S_CHECK;
      S_CHECK: if (run_last_c)  state_d = S_DONE;
      S_DONE:  if (start)       state_d = S_WARM;
      default:                  state_d = S_IDLE;
    endcase
  end

  // Next values for counters, flags and registered outputs
  always_comb begin
    warm_d = '0;
    run_d  = run_q;
    chk_d  = chk_cnt;
    err_d  = err_cnt;
    und_d  = underrun;
    mis_d  = 1'b0;
    cnt_d  = cnt_q;

    if (state_q == S_WARM && !warm_last_c) warm_d = warm_q + WW'(1);

    if (run_start_c) begin
      run_d = '0;
      chk_d = '0;
      err_d = '0;
      und_d = 1'b0;
    end

    if (in_check_c) begin
      run_d = run_q + RW'(1);
      chk_d = chk_cnt + CW'(1);
      if (miss_c) begin
        mis_d = 1'b1;
        if (err_cnt != '1) err_d = err_cnt + CW'(1);
        if (fifo_empty_c)  und_d = 1'b1;
      end
    end

    case ({push_c, pop_c})
      2'b10:   cnt_d = cnt_q + OW'(1);
      2'b01:   cnt_d = cnt_q - OW'(1);
      default: cnt_d = cnt_q;
    endcase

    busy_d  = (state_d == S_WARM) || (state_d == S_CHECK);
    done_d  = (state_d == S_DONE);
    pass_d  = done_d && (err_d == '0) && !und_d;
    ready_d = (cnt_d != OW'(DEPTH));
  end

  // Output and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      warm_q     <= '0;
      run_q      <= '0;
      chk_cnt    <= '0;
      err_cnt    <= '0;
      underrun   <= 1'b0;
      mismatch   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      gold_ready <= 1'b1;
      cnt_q      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      warm_q     <= warm_d;
      run_q      <= run_d;
      chk_cnt    <= chk_d;
      err_cnt    <= err_d;
      underrun   <= und_d;
      mismatch   <= mis_d;
      busy       <= busy_d;
      done       <= done_d;
      pass       <= pass_d;
      gold_ready <= ready_d;
      cnt_q      <= cnt_d;
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Golden storage; contents are qualified by the occupancy count
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= gold_data;
  end

`ifdef CS_CHK_FIRSTERR_EN
  // err_cnt is still zero on the first failed compare of a run
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first_idx <= '0;
      first_exp <= '0;
      first_act <= '0;
    end else if (run_start_c) begin
      first_idx <= '0;
      first_exp <= '0;
      first_act <= '0;
    end else if (miss_c && err_cnt == '0) begin
      first_idx <= chk_cnt;
      first_exp <= fifo_empty_c ? '0 : head_c;
      first_act <= Y;
    end
  end
`else
  assign first_idx = '0;
  assign first_exp = '0;
  assign first_act = '0;
`endif

endmodule

// File: tb/tb_cs_stream_checker.sv
// Directed bench for cs_stream_checker: full-match run, single mismatch,
// underrun with slow golden feed, FIFO full/ready behaviour, mid-run reset
// and error-counter saturation on a narrow-counter instance.
module tb_cs_stream_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, gold_valid;
  logic [9:0]  y, gold_data;
  logic        gold_ready, busy, done, pass, mismatch, underrun;
  logic [15:0] chk_cnt, err_cnt, first_idx;
  logic [9:0]  first_exp, first_act;

  logic        s_start, s_gv;
  logic [9:0]  s_y, s_gd;
  logic        s_ready, s_busy, s_done, s_pass, s_mis, s_und;
  logic [3:0]  s_chk, s_err, s_fidx;
  logic [9:0]  s_fexp, s_fact;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  cs_stream_checker #(.DW(10), .DEPTH(16), .WARMUP(9), .N_CHK(16), .CW(16)) u_dut (
    .clk(clk), .reset(rst_n), .start(start), .Y(y),
    .gold_data(gold_data), .gold_valid(gold_valid), .gold_ready(gold_ready),
    .busy(busy), .done(done), .pass(pass), .mismatch(mismatch),
    .underrun(underrun), .chk_cnt(chk_cnt), .err_cnt(err_cnt),
    .first_idx(first_idx), .first_exp(first_exp), .first_act(first_act)
  );

  cs_stream_checker #(.DW(10), .DEPTH(16), .WARMUP(9), .N_CHK(20), .CW(4)) u_sat (
    .clk(clk), .reset(rst_n), .start(s_start), .Y(s_y),
    .gold_data(s_gd), .gold_valid(s_gv), .gold_ready(s_ready),
    .busy(s_busy), .done(s_done), .pass(s_pass), .mismatch(s_mis),
    .underrun(s_und), .chk_cnt(s_chk), .err_cnt(s_err),
    .first_idx(s_fidx), .first_exp(s_fexp), .first_act(s_fact)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [9:0] w);
    gold_valid = 1'b1;
    gold_data  = w;
    tick();
    gold_valid = 1'b0;
  endtask

  task automatic start_and_warm();
    start = 1'b1;
    tick();
    start = 1'b0;
    y = 10'h2AA;
    repeat (9) tick();
  endtask

  logic [9:0] q[$];
  int         exp_err;
  logic       exp_miss;

  initial begin
    rst_n = 1'b0; start = 1'b0; gold_valid = 1'b0; gold_data = '0; y = '0;
    s_start = 1'b0; s_gv = 1'b0; s_gd = '0; s_y = '0;
    repeat (2) tick();
    chk("rst_gold_ready", gold_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_chk_cnt", chk_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    tick();

    // Run 1: all compares match; also FIFO-full backpressure
    for (int i = 0; i < 16; i++) push_word(10'(i));
    chk("full_ready_low", gold_ready, 0);
    gold_valid = 1'b1; gold_data = 10'h3AA;
    tick();
    gold_valid = 1'b0;
    chk("full_push_rejected_ready", gold_ready, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("warm_busy", busy, 1);
    y = 10'h2AA;
    repeat (9) tick();
    chk("warm_no_compare", chk_cnt, 0);
    for (int k = 0; k < 16; k++) begin
      y = 10'(k);
      tick();
      chk("r1_chk_cnt", chk_cnt, k + 1);
      chk("r1_mismatch", mismatch, 0);
      chk("r1_done", done, (k == 15) ? 1 : 0);
      if (k == 0) chk("pop_frees_slot", gold_ready, 1);
    end
    chk("r1_pass", pass, 1);
    chk("r1_err_cnt", err_cnt, 0);
    chk("r1_busy", busy, 0);
    chk("r1_underrun", underrun, 0);
    tick();
    chk("r1_done_held", done, 1);

    // Run 2: one mismatch on the 6th compare
    for (int i = 0; i < 16; i++) push_word(10'(i));
    start_and_warm();
    for (int k = 0; k < 16; k++) begin
      y = (k == 5) ? 10'h3FF : 10'(k);
      tick();
      chk("r2_mismatch", mismatch, (k == 5) ? 1 : 0);
      chk("r2_err_cnt", err_cnt, (k >= 5) ? 1 : 0);
    end
    chk("r2_done", done, 1);
    chk("r2_pass", pass, 0);
    chk("r2_underrun", underrun, 0);
`ifdef CS_CHK_FIRSTERR_EN
    chk("r2_first_idx", first_idx, 5);
    chk("r2_first_exp", first_exp, 10'h005);
    chk("r2_first_act", first_act, 10'h3FF);
`else
    chk("r2_first_idx_tied", first_idx, 0);
    chk("r2_first_exp_tied", first_exp, 0);
    chk("r2_first_act_tied", first_act, 0);
`endif

    // Run 3: golden fed every other cycle starting from an empty FIFO
    start_and_warm();
    chk("r3_cleared_err", err_cnt, 0);
    exp_err = 0;
    for (int k = 0; k < 16; k++) begin
      exp_miss   = (q.size() == 0);
      y          = exp_miss ? 10'h155 : q[0];
      gold_valid = (k % 2 == 0);
      gold_data  = 10'h100 + 10'(k);
      tick();
      if (!exp_miss) void'(q.pop_front());
      if (gold_valid) q.push_back(gold_data);
      if (exp_miss) exp_err++;
      chk("r3_mismatch", mismatch, exp_miss);
      chk("r3_err_cnt", err_cnt, exp_err);
    end
    gold_valid = 1'b0;
    chk("r3_err_total", err_cnt, 8);
    chk("r3_underrun", underrun, 1);
    chk("r3_pass", pass, 0);
    chk("r3_done", done, 1);
`ifdef CS_CHK_FIRSTERR_EN
    chk("r3_first_idx", first_idx, 0);
    chk("r3_first_exp", first_exp, 0);
    chk("r3_first_act", first_act, 10'h155);
`endif

    // Run 4: reset mid-CHECK at chk_cnt=7
    for (int i = 0; i < 16; i++) push_word(10'(i));
    start_and_warm();
    for (int k = 0; k < 7; k++) begin
      y = 10'(k);
      tick();
    end
    chk("r4_chk_before_rst", chk_cnt, 7);
    rst_n = 1'b0;
    #1;
    chk("r4_async_busy", busy, 0);
    chk("r4_async_chk_cnt", chk_cnt, 0);
    chk("r4_async_err_cnt", err_cnt, 0);
    chk("r4_async_ready", gold_ready, 1);
    chk("r4_async_done", done, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Restart after reset: leftover words would cause mismatches
    for (int i = 0; i < 16; i++) push_word(10'h20 + 10'(i));
    chk("r5_full", gold_ready, 0);
    start_and_warm();
    for (int k = 0; k < 16; k++) begin
      y = 10'h20 + 10'(k);
      gold_valid = (k == 1);
      gold_data  = 10'h030;
      tick();
      gold_valid = 1'b0;
      if (k == 1) chk("pushpop_count_15", gold_ready, 1);
      chk("r5_mismatch", mismatch, 0);
    end
    chk("r5_done", done, 1);
    chk("r5_pass", pass, 1);
    chk("r5_chk_cnt", chk_cnt, 16);
    chk("r5_err_cnt", err_cnt, 0);

    // Saturation: 4-bit error counter, 20 underrun compares
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    repeat (9) tick();
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("sat_err_cnt", s_err, (k + 1 > 15) ? 15 : k + 1);
      chk("sat_mismatch", s_mis, 1);
    end
    chk("sat_done", s_done, 1);
    chk("sat_pass", s_pass, 0);
    chk("sat_underrun", s_und, 1);
    tick();
    chk("sat_err_held", s_err, 4'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/cs_stream_checker.md
Name: cs_stream_checker

Overview:
- On-chip self-checker for the CS smoothing datapath. Consumes the 10-bit Y stream one word per clock and compares it against golden words preloaded into an internal FIFO through a valid/ready handshake.
- Counts checks and mismatches and reports pass/fail.
- Sits at the output end of the CS interface. Replaces the file-based golden comparison for silicon and FPGA bring-up.

Parameters:
- DW, 10, width of Y and golden words
- DEPTH, 16, golden FIFO depth in words; power of two, minimum 2
- WARMUP, 9, cycles after start during which Y is ignored (CS window fill)
- N_CHK, 1992, number of Y words compared per run
- CW, 16, width of the check and error counters

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a run
- Y  in  DW  CS output word, sampled every clock in CHECK
- gold_data  in  DW  golden word
- gold_valid  in  1  gold_data valid
- gold_ready  out  1  FIFO can accept a word
- busy  out  1  high in WARM or CHECK
- done  out  1  high in DONE
- pass  out  1  valid in DONE: error count is 0 and no underrun occurred
- mismatch  out  1  one-cycle pulse per failed compare
- underrun  out  1  sticky; a compare found the FIFO empty
- chk_cnt  out  CW  compares performed this run
- err_cnt  out  CW  failed compares, saturating at all-ones

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE; FIFO emptied.
  - All counters and flags = 0; gold_ready = 1.
- State machine (IDLE, WARM, CHECK, DONE):
  - IDLE, start=1 -> WARM.
  - WARM: warm counter runs from 0; on the cycle it equals WARMUP-1 -> CHECK. Y ignored; exactly WARMUP cycles are spent in WARM.
  - CHECK: one compare per clock. The compare at which chk_cnt reaches N_CHK -> DONE.
  - DONE, start=1 -> WARM.
  - start in WARM or CHECK is ignored.
- Run start (entry to WARM from IDLE or DONE):
  - Clears chk_cnt, err_cnt and underrun.
  - The FIFO is not flushed, so golden words may be preloaded while IDLE or DONE.
- FIFO:
  - gold_ready = not full.
  - Push on gold_valid & gold_ready, in any state.
  - Pop only on a CHECK compare with the FIFO non-empty.
  - Push and pop in the same cycle: occupancy unchanged. When full, ready is low, so no push occurs.
  - No bypass: a word pushed into an empty FIFO can be compared on the next cycle at the earliest.
  - Pointers wrap modulo DEPTH; a separate occupancy count (0..DEPTH) distinguishes full from empty.
- Compare (each CHECK cycle):
  - FIFO non-empty: compare Y to the head word, 4-state exact (equality). Mismatch -> err_cnt+1 and mismatch=1 on the next cycle.
  - FIFO empty: underrun=1 (sticky), err_cnt+1, mismatch=1, no pop.
  - chk_cnt+1 in every CHECK cycle.
  - All outputs are registered. chk_cnt, err_cnt and mismatch reflect a compare one clock after its sampling edge.
- err_cnt saturates at 2^CW-1 and never wraps.
- done=1 and pass valid from the cycle DONE is entered. Both hold until the next start or reset.
- Mid-run reset: immediate return to IDLE, FIFO emptied, no partial results retained.

Optional Feature:
- Macro CS_CHK_FIRSTERR_EN.
- Defined: adds outputs first_idx (CW), first_exp (DW) and first_act (DW).
  - On the first failed compare of a run, these latch the chk_cnt value before increment, the expected word and Y.
  - Held until the next run start. On underrun, first_exp = 0.
- Undefined: those ports still exist but are tied to 0; no capture logic is built.

Test Plan:
- Preload 16 golden words 0x000..0x00F. Start, with Y matching each word on its CHECK cycle, N_CHK=16 -> done after 9+16 cycles; pass=1, chk_cnt=16, err_cnt=0.
- Same run, with Y=0x3FF instead of 0x005 on the 6th compare -> a single mismatch pulse; err_cnt=1, pass=0. With CS_CHK_FIRSTERR_EN defined: first_idx=5, first_exp=0x005, first_act=0x3FF.
- Golden fed at 1 word per 2 cycles, FIFO initially empty at CHECK entry -> underrun=1; err_cnt counts each empty-FIFO compare; pass=0.
- Fill the FIFO with DEPTH=16 words -> gold_ready=0; a push attempt with gold_valid=1 is not accepted. One pop frees a slot -> gold_ready=1 the next cycle. Push and pop in the same cycle keep the count at 15.
- CW=4, all 20 compares mismatching -> err_cnt saturates at 0xF, no wrap.
- Assert reset low mid-CHECK, at chk_cnt=7 -> IDLE immediately; chk_cnt=0, err_cnt=0, FIFO empty, gold_ready=1. A restart then completes a full run correctly.
